ex_stage_mdu: RTL and testbench

//  Parametrised EX stage for the 5-stage MIPS pipeline, with an EX/MEM register and valid/stall handshaking.

---
 rtl/ex_pkg.sv | 59 +++++
 rtl/ex_stage_mdu_if.sv | 57 +++++
 rtl/mdu_iter.sv | 81 ++++++++
 rtl/ex_stage_mdu.sv | 181 ++++++++++++++++++
 tb/tb_ex_stage_mdu.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/ex_pkg.sv
// Shared definitions for the EX stage with multiply/divide unit.
// Holds the internal ALU control codes, the R-type funct constants the
// stage decodes, the multiplier FSM state enum and the ALU decoder.
package ex_pkg;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_AND   = 4'd2,
    ALU_OR    = 4'd3,
    ALU_SLT   = 4'd4,
    ALU_MULT  = 4'd5,
    ALU_MULTU = 4'd6,
    ALU_MFHI  = 4'd7,
    ALU_MFLO  = 4'd8
  } alu_ctl_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mdu_state_e;

  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_SLT   = 6'h2A;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MFLO  = 6'h12;

  // Main-decoder class plus funct to internal ALU operation; unknown functs add.
  function automatic alu_ctl_e alu_decode(input logic [1:0] alu_op, input logic [5:0] funct);
    alu_ctl_e ctl;
    case (alu_op)
      2'b00: ctl = ALU_ADD;
      2'b01: ctl = ALU_SUB;
      2'b10: begin
        case (funct)
          FN_ADD:   ctl = ALU_ADD;
          FN_SUB:   ctl = ALU_SUB;
          FN_AND:   ctl = ALU_AND;
          FN_OR:    ctl = ALU_OR;
          FN_SLT:   ctl = ALU_SLT;
          FN_MULT:  ctl = ALU_MULT;
          FN_MULTU: ctl = ALU_MULTU;
          FN_MFHI:  ctl = ALU_MFHI;
          FN_MFLO:  ctl = ALU_MFLO;
          default:  ctl = ALU_ADD;
        endcase
      end
      default: ctl = ALU_ADD;
    endcase
    return ctl;
  endfunction

endpackage

// File: rtl/ex_stage_mdu_if.sv
// ID/EX -> EX -> EX/MEM bundle for the EX stage.
// master: the surrounding pipeline (drives the ID/EX fields, forwarding
//         sources and mem_stall; observes ex_ready and the EX/MEM register).
// slave : the EX stage itself.
interface ex_stage_mdu_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            id_valid;
  logic            ex_ready;
  logic [1:0]      ctlwb_in;
  logic [1:0]      ctlm_in;
  logic [XLEN-1:0] npc;
  logic [XLEN-1:0] rdata1;
  logic [XLEN-1:0] rdata2;
  logic [XLEN-1:0] s_extend;
  logic [RA_W-1:0] instr_2521;
  logic [RA_W-1:0] instr_2016;
  logic [RA_W-1:0] instr_1511;
  logic [1:0]      alu_op;
  logic [5:0]      funct;
  logic            alusrc;
  logic            regdst;
  logic            mem_regwrite;
  logic [RA_W-1:0] mem_rd;
  logic [XLEN-1:0] mem_fwd_data;
  logic            wb_regwrite;
  logic [RA_W-1:0] wb_rd;
  logic [XLEN-1:0] wb_fwd_data;
  logic            mem_stall;
  logic            ex_valid_out;
  logic [1:0]      ctlwb_out;
  logic [1:0]      ctlm_out;
  logic [XLEN-1:0] adder_out;
  logic [XLEN-1:0] alu_result_out;
  logic [XLEN-1:0] rdata2_out;
  logic [RA_W-1:0] muxout_out;
  logic            zero_out;

  modport master (
    output id_valid, ctlwb_in, ctlm_in, npc, rdata1, rdata2, s_extend,
           instr_2521, instr_2016, instr_1511, alu_op, funct, alusrc, regdst,
           mem_regwrite, mem_rd, mem_fwd_data, wb_regwrite, wb_rd, wb_fwd_data,
           mem_stall,
    input  ex_ready, ex_valid_out, ctlwb_out, ctlm_out, adder_out,
           alu_result_out, rdata2_out, muxout_out, zero_out
  );

  modport slave (
    input  id_valid, ctlwb_in, ctlm_in, npc, rdata1, rdata2, s_extend,
           instr_2521, instr_2016, instr_1511, alu_op, funct, alusrc, regdst,
           mem_regwrite, mem_rd, mem_fwd_data, wb_regwrite, wb_rd, wb_fwd_data,
           mem_stall,
    output ex_ready, ex_valid_out, ctlwb_out, ctlm_out, adder_out,
           alu_result_out, rdata2_out, muxout_out, zero_out
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative shift-add multiplier datapath.
// Ports: clk, rst_n (sync, active-low); start latches the operands
// (magnitudes when is_signed) and loads the counter; step performs one
// shift-add; last flags the final step; product is the sign-corrected
// 2*XLEN result of the step currently being performed.
module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              is_signed,
  input  logic              step,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  output logic              last,
  output logic [2*XLEN-1:0] product
);
  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(XLEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [XLEN-1:0]   mcand_q, mcand_d;
  logic [2*XLEN-1:0] acc_q, acc_d;   // {partial sum, remaining multiplier bits}
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              neg_q, neg_d;
  logic [XLEN:0]     sum_s;
  logic [2*XLEN-1:0] shifted_s;

  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v, input logic sgn);
    if (sgn && v[XLEN-1]) begin
      return -v;
    end else begin
      return v;
    end
  endfunction

  // One shift-add step and the next-state selection for the datapath.
  always_comb begin
    mcand_d = mcand_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    neg_d   = neg_q;
    sum_s     = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
    shifted_s = {sum_s, acc_q[XLEN-1:1]};
    if (start) begin
      mcand_d = magnitude(op_a, is_signed);
      acc_d   = {{XLEN{1'b0}}, magnitude(op_b, is_signed)};
      cnt_d   = CNT_INIT;
      neg_d   = is_signed & (op_a[XLEN-1] ^ op_b[XLEN-1]);
    end else if (step) begin
      acc_d = shifted_s;
      cnt_d = cnt_q - CNT_ONE;
    end else begin
      acc_d = acc_q;
    end
    // Sign fix applied to the finished magnitude product.
    if (neg_q) begin
      product = -shifted_s;
    end else begin
      product = shifted_s;
    end
  end

  assign last = (cnt_q == {CNT_W{1'b0}});

  // Datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mcand_q <= {XLEN{1'b0}};
      acc_q   <= {(2*XLEN){1'b0}};
      cnt_q   <= {CNT_W{1'b0}};
      neg_q   <= 1'b0;
    end else begin
      mcand_q <= mcand_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      neg_q   <= neg_d;
    end
  end
endmodule

// File: rtl/ex_stage_mdu.sv
// EX stage of the 5-stage MIPS pipeline: forwarding, single-cycle ALU,
// branch-target adder, HI/LO pair with an iterative MULT/MULTU unit, and
// the EX/MEM register with valid/stall handshake.
// Ports: clk, rst_n (sync, active-low); bus (slave side) carries the ID/EX
// fields, forwarding sources, mem_stall, ex_ready and EX/MEM contents.
module ex_stage_mdu
  import ex_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int RA_W     = 5,
  parameter int BR_SHIFT = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  ex_stage_mdu_if.slave bus
);
  mdu_state_e      state_q, state_d;
  logic [XLEN-1:0] hi_q, hi_d, lo_q, lo_d;
  logic            ex_valid_q, ex_valid_d;
  logic [1:0]      ctlwb_q, ctlwb_d, ctlm_q, ctlm_d;
  logic [XLEN-1:0] adder_q, adder_d, alu_result_q, alu_result_d, rdata2_q, rdata2_d;
  logic [RA_W-1:0] muxout_q, muxout_d;
  logic            zero_q, zero_d;

  logic [XLEN-1:0]   fwd_a_s, fwd_b_s, op_b_s, alu_res_s;
  alu_ctl_e          alu_ctl_s;
  logic              mult_start_s, mult_signed_s, mdu_step_s, advance_s, mdu_last_s;
  logic [2*XLEN-1:0] mdu_prod_s;

  // Operand forwarding (MEM beats WB beats register file) and the ALU.
  always_comb begin
    if (bus.mem_regwrite && (bus.mem_rd != {RA_W{1'b0}}) && (bus.mem_rd == bus.instr_2521)) begin
      fwd_a_s = bus.mem_fwd_data;
    end else if (bus.wb_regwrite && (bus.wb_rd != {RA_W{1'b0}}) && (bus.wb_rd == bus.instr_2521)) begin
      fwd_a_s = bus.wb_fwd_data;
    end else begin
      fwd_a_s = bus.rdata1;
    end
    if (bus.mem_regwrite && (bus.mem_rd != {RA_W{1'b0}}) && (bus.mem_rd == bus.instr_2016)) begin
      fwd_b_s = bus.mem_fwd_data;
    end else if (bus.wb_regwrite && (bus.wb_rd != {RA_W{1'b0}}) && (bus.wb_rd == bus.instr_2016)) begin
      fwd_b_s = bus.wb_fwd_data;
    end else begin
      fwd_b_s = bus.rdata2;
    end
    op_b_s    = bus.alusrc ? bus.s_extend : fwd_b_s;
    alu_ctl_s = alu_decode(bus.alu_op, bus.funct);
    case (alu_ctl_s)
      ALU_ADD:  alu_res_s = fwd_a_s + op_b_s;
      ALU_SUB:  alu_res_s = fwd_a_s - op_b_s;
      ALU_AND:  alu_res_s = fwd_a_s & op_b_s;
      ALU_OR:   alu_res_s = fwd_a_s | op_b_s;
      ALU_SLT:  alu_res_s = ($signed(fwd_a_s) < $signed(op_b_s)) ? {{(XLEN-1){1'b0}}, 1'b1} : {XLEN{1'b0}};
      ALU_MFHI: alu_res_s = hi_q;
      ALU_MFLO: alu_res_s = lo_q;
      default:  alu_res_s = {XLEN{1'b0}};  // MULT/MULTU produce no ALU result
    endcase
  end

  assign mult_signed_s = (alu_ctl_s == ALU_MULT);
  assign mult_start_s  = (state_q == ST_IDLE) && bus.id_valid &&
                         ((alu_ctl_s == ALU_MULT) || (alu_ctl_s == ALU_MULTU));
  assign mdu_step_s    = (state_q == ST_BUSY);
  assign advance_s     = !bus.mem_stall;
  assign bus.ex_ready  = (state_q != ST_BUSY) && !mult_start_s && !bus.mem_stall;

  mdu_iter #(.XLEN(XLEN)) u_mdu (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (mult_start_s),
    .is_signed (mult_signed_s),
    .step      (mdu_step_s),
    .op_a      (fwd_a_s),
    .op_b      (fwd_b_s),
    .last      (mdu_last_s),
    .product   (mdu_prod_s)
  );

  // Multiplier FSM next state, HI/LO update and EX/MEM load selection.
  always_comb begin
    state_d      = state_q;
    hi_d         = hi_q;
    lo_d         = lo_q;
    ex_valid_d   = ex_valid_q;
    ctlwb_d      = ctlwb_q;
    ctlm_d       = ctlm_q;
    adder_d      = adder_q;
    alu_result_d = alu_result_q;
    rdata2_d     = rdata2_q;
    muxout_d     = muxout_q;
    zero_d       = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (mult_start_s) begin
          state_d = ST_BUSY;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_BUSY: begin
        // The multiplier keeps stepping regardless of mem_stall.
        if (mdu_last_s) begin
          state_d = ST_DONE;
          hi_d    = mdu_prod_s[2*XLEN-1:XLEN];
          lo_d    = mdu_prod_s[XLEN-1:0];
        end else begin
          state_d = ST_BUSY;
        end
      end
      ST_DONE: begin
        if (advance_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (advance_s) begin
      adder_d      = bus.npc + (bus.s_extend << BR_SHIFT);
      alu_result_d = alu_res_s;
      rdata2_d     = fwd_b_s;
      muxout_d     = bus.regdst ? bus.instr_1511 : bus.instr_2016;
      zero_d       = (alu_res_s == {XLEN{1'b0}});
      if ((state_q == ST_BUSY) || mult_start_s) begin
        ex_valid_d = 1'b0;
        ctlwb_d    = 2'b00;
        ctlm_d     = 2'b00;
      end else if (state_q == ST_DONE) begin
        // Retiring MULT: travels down the pipe but writes nothing.
        ex_valid_d = bus.id_valid;
        ctlwb_d    = 2'b00;
        ctlm_d     = 2'b00;
      end else begin
        ex_valid_d = bus.id_valid;
        ctlwb_d    = bus.id_valid ? bus.ctlwb_in : 2'b00;
        ctlm_d     = bus.id_valid ? bus.ctlm_in : 2'b00;
      end
    end else begin
      ex_valid_d = ex_valid_q;
    end
  end

  // FSM state, HI/LO and EX/MEM register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      hi_q         <= {XLEN{1'b0}};
      lo_q         <= {XLEN{1'b0}};
      ex_valid_q   <= 1'b0;
      ctlwb_q      <= 2'b00;
      ctlm_q       <= 2'b00;
      adder_q      <= {XLEN{1'b0}};
      alu_result_q <= {XLEN{1'b0}};
      rdata2_q     <= {XLEN{1'b0}};
      muxout_q     <= {RA_W{1'b0}};
      zero_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      hi_q         <= hi_d;
      lo_q         <= lo_d;
      ex_valid_q   <= ex_valid_d;
      ctlwb_q      <= ctlwb_d;
      ctlm_q       <= ctlm_d;
      adder_q      <= adder_d;
      alu_result_q <= alu_result_d;
      rdata2_q     <= rdata2_d;
      muxout_q     <= muxout_d;
      zero_q       <= zero_d;
    end
  end

  assign bus.ex_valid_out   = ex_valid_q;
  assign bus.ctlwb_out      = ctlwb_q;
  assign bus.ctlm_out       = ctlm_q;
  assign bus.adder_out      = adder_q;
  assign bus.alu_result_out = alu_result_q;
  assign bus.rdata2_out     = rdata2_q;
  assign bus.muxout_out     = muxout_q;
  assign bus.zero_out       = zero_q;
endmodule

// File: tb/tb_ex_stage_mdu.sv
// Directed self-checking bench for ex_stage_mdu (XLEN=32).
module tb_ex_stage_mdu;
  import ex_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  ex_stage_mdu_if #(.XLEN(32), .RA_W(5)) bus ();

  ex_stage_mdu #(.XLEN(32), .RA_W(5), .BR_SHIFT(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clk = ~clk;

  // Single comparison point: counts and reports.
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_fwd();
    bus.mem_regwrite = 1'b0; bus.mem_rd = 5'd0; bus.mem_fwd_data = 32'd0;
    bus.wb_regwrite  = 1'b0; bus.wb_rd  = 5'd0; bus.wb_fwd_data  = 32'd0;
  endtask

  // R-type instruction: rs=1, rt=2, rd=3.
  task automatic r_op(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    bus.id_valid = 1'b1; bus.alu_op = 2'b10; bus.funct = fn;
    bus.alusrc = 1'b0; bus.regdst = 1'b1;
    bus.instr_2521 = 5'd1; bus.instr_2016 = 5'd2; bus.instr_1511 = 5'd3;
    bus.rdata1 = a; bus.rdata2 = b;
    bus.ctlwb_in = 2'b10; bus.ctlm_in = 2'b00;
    bus.npc = 32'h0000_0040; bus.s_extend = 32'h0000_0001;
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    r_op(FN_MFHI, 32'd0, 32'd0);
    tick();
    check({tag, "_mfhi"}, bus.alu_result_out, hi);
    r_op(FN_MFLO, 32'd0, 32'd0);
    tick();
    check({tag, "_mflo"}, bus.alu_result_out, lo);
  endtask

  // Issue a multiply, count ex_ready-low cycles, optionally stall in DONE, retire.
  task automatic run_mult(input string tag, input logic [5:0] fn, input logic [31:0] a,
                          input logic [31:0] b, input int done_stall);
    int n;
    r_op(fn, a, b);
    bus.ctlwb_in = 2'b11; bus.ctlm_in = 2'b11;
    #1;
    n = 0;
    while (bus.ex_ready !== 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check({tag, "_busy_cycles"}, n, 33);
    check({tag, "_bubble"}, bus.ex_valid_out, 1'b0);
    if (done_stall > 0) begin
      bus.mem_stall = 1'b1;
      for (int i = 0; i < done_stall; i++) begin
        #1;
        check({tag, "_done_stall_ready"}, bus.ex_ready, 1'b0);
        tick();
        check({tag, "_done_stall_hold"}, bus.ex_valid_out, 1'b0);
      end
      bus.mem_stall = 1'b0;
    end
    tick();
    check({tag, "_retire_valid"}, bus.ex_valid_out, 1'b1);
    check({tag, "_retire_ctlwb"}, bus.ctlwb_out, 2'b00);
    check({tag, "_retire_ctlm"}, bus.ctlm_out, 2'b00);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    clk = 1'b0;
    rst_n = 1'b0;
    bus.mem_stall = 1'b0;
    clear_fwd();
    r_op(FN_ADD, 32'd0, 32'd0);
    bus.id_valid = 1'b0;
    tick();
    tick();

    // Reset state
    check("rst_valid", bus.ex_valid_out, 1'b0);
    check("rst_alu", bus.alu_result_out, 32'd0);
    check("rst_adder", bus.adder_out, 32'd0);
    check("rst_ctl", {bus.ctlwb_out, bus.ctlm_out}, 4'd0);
    check("rst_rdata2", bus.rdata2_out, 32'd0);
    check("rst_muxout", bus.muxout_out, 5'd0);
    check("rst_zero", bus.zero_out, 1'b0);
    check("rst_ready", bus.ex_ready, 1'b1);
    rst_n = 1'b1;

    // 1: add with rs forwarded from MEM
    r_op(FN_ADD, 32'd100, 32'd3);
    bus.instr_2521 = 5'd4; bus.instr_2016 = 5'd5; bus.instr_1511 = 5'd6;
    bus.ctlm_in = 2'b01; bus.npc = 32'h100; bus.s_extend = 32'd4;
    bus.mem_regwrite = 1'b1; bus.mem_rd = 5'd4; bus.mem_fwd_data = 32'd5;
    tick();
    check("t1_alu", bus.alu_result_out, 32'd8);
    check("t1_valid", bus.ex_valid_out, 1'b1);
    check("t1_ctlwb", bus.ctlwb_out, 2'b10);
    check("t1_ctlm", bus.ctlm_out, 2'b01);
    check("t1_muxout", bus.muxout_out, 5'd6);
    check("t1_rdata2", bus.rdata2_out, 32'd3);
    check("t1_adder", bus.adder_out, 32'h110);
    check("t1_zero", bus.zero_out, 1'b0);

    // 2: MEM beats WB; rd=0 never forwards; WB alone; rt forwarded from WB
    bus.mem_fwd_data = 32'd7;
    bus.wb_regwrite = 1'b1; bus.wb_rd = 5'd4; bus.wb_fwd_data = 32'd9;
    tick();
    check("t2_mem_prio", bus.alu_result_out, 32'd10);
    bus.mem_regwrite = 1'b0;
    tick();
    check("t2_wb_only", bus.alu_result_out, 32'd12);
    clear_fwd();
    r_op(FN_ADD, 32'd20, 32'd3);
    bus.instr_2521 = 5'd0;
    bus.mem_regwrite = 1'b1; bus.mem_rd = 5'd0; bus.mem_fwd_data = 32'd77;
    tick();
    check("t2_rd0_nofwd", bus.alu_result_out, 32'd23);
    clear_fwd();
    r_op(FN_ADD, 32'd1, 32'd100);
    bus.wb_regwrite = 1'b1; bus.wb_rd = 5'd2; bus.wb_fwd_data = 32'd9;
    tick();
    check("t2_rt_fwd_alu", bus.alu_result_out, 32'd10);
    check("t2_rt_fwd_rdata2", bus.rdata2_out, 32'd9);
    clear_fwd();

    // ALU operations, immediate path, bubbles
    r_op(FN_ADD, 32'd5, 32'd5);
    bus.alu_op = 2'b01;
    tick();
    check("beq_sub_zero", bus.zero_out, 1'b1);
    r_op(FN_AND, 32'h0000_F0F0, 32'h0000_FF00);
    tick();
    check("and", bus.alu_result_out, 32'h0000_F000);
    r_op(FN_OR, 32'h0000_F0F0, 32'h0000_FF00);
    tick();
    check("or", bus.alu_result_out, 32'h0000_FFF0);
    r_op(FN_SLT, 32'hFFFF_FFFF, 32'd1);
    tick();
    check("slt_neg", bus.alu_result_out, 32'd1);
    r_op(FN_SLT, 32'd1, 32'hFFFF_FFFF);
    tick();
    check("slt_pos", bus.alu_result_out, 32'd0);
    r_op(FN_SUB, 32'd50, 32'd8);
    tick();
    check("sub", bus.alu_result_out, 32'd42);
    r_op(6'h27, 32'd6, 32'd7);
    tick();
    check("unknown_funct_add", bus.alu_result_out, 32'd13);
    r_op(FN_ADD, 32'h1000, 32'd0);
    bus.alu_op = 2'b00; bus.alusrc = 1'b1; bus.regdst = 1'b0; bus.s_extend = 32'h10;
    tick();
    check("lw_imm", bus.alu_result_out, 32'h1010);
    check("lw_muxout_rt", bus.muxout_out, 5'd2);
    bus.id_valid = 1'b0;
    tick();
    check("bubble_valid", bus.ex_valid_out, 1'b0);
    check("bubble_ctlwb", bus.ctlwb_out, 2'b00);

    // 3: signed MULT -3 x 4, then MFHI/MFLO
    run_mult("t3", FN_MULT, 32'hFFFF_FFFD, 32'd4, 0);
    read_hilo("t3", 32'hFFFF_FFFF, 32'hFFFF_FFF4);
    run_mult("neg_neg", FN_MULT, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 0);
    read_hilo("neg_neg", 32'd0, 32'd6);

    // 4: MULTU 0xFFFFFFFF x 2
    run_mult("t4", FN_MULTU, 32'hFFFF_FFFF, 32'd2, 0);
    read_hilo("t4", 32'd1, 32'hFFFF_FFFE);

    // 5: stall on a single-cycle op, then stall in DONE
    r_op(FN_ADD, 32'd10, 32'd20);
    tick();
    check("t5_first", bus.alu_result_out, 32'd30);
    r_op(FN_SUB, 32'd50, 32'd8);
    bus.mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t5_stall_ready", bus.ex_ready, 1'b0);
      tick();
      check("t5_stall_hold", bus.alu_result_out, 32'd30);
    end
    bus.mem_stall = 1'b0;
    tick();
    check("t5_release", bus.alu_result_out, 32'd42);
    check("t5_release_valid", bus.ex_valid_out, 1'b1);
    run_mult("t5m", FN_MULTU, 32'd3, 32'd5, 3);
    read_hilo("t5m", 32'd0, 32'd15);

    // 6: reset in the 10th BUSY cycle abandons the multiply
    r_op(FN_MULT, 32'd7, 32'd9);
    repeat (10) tick();
    rst_n = 1'b0;
    bus.id_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    check("t6_ready", bus.ex_ready, 1'b1);
    check("t6_valid", bus.ex_valid_out, 1'b0);
    check("t6_alu", bus.alu_result_out, 32'd0);
    check("t6_adder", bus.adder_out, 32'd0);
    check("t6_ctl", {bus.ctlwb_out, bus.ctlm_out}, 4'd0);
    check("t6_zero", bus.zero_out, 1'b0);
    read_hilo("t6", 32'd0, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
